// File: rtl/fpu_mul_pkg.sv
// -----------------------------------------------------------------------------
// fpu_mul_pkg
// Shared constants and types for the FPU mantissa multiplier back end.
//   MUL_PROD_W : product width (A/B vector width)
//   MUL_SEG_W  : low-segment width of the final carry-propagate adder
//   MUL_TAG_W  : default sideband tag width
//   mul_prod_t : one product vector
//   mul_s1_t   : stage-1 register layout of mul_final_cpa_pipe
// Optional feature macro: MUL_CPA_STICKY_EN adds guard/sticky candidates.
// -----------------------------------------------------------------------------
package fpu_mul_pkg;

   localparam int unsigned MUL_PROD_W = 48;
   localparam int unsigned MUL_SEG_W  = 24;
   localparam int unsigned MUL_TAG_W  = 4;

   typedef logic [MUL_PROD_W-1:0] mul_prod_t;

   typedef struct packed {
      logic [MUL_SEG_W-1:0]            lo;     // resolved low segment
      logic                            c_seg;  // carry into the high segment
      logic [MUL_PROD_W-MUL_SEG_W-1:0] a_hi;
      logic [MUL_PROD_W-MUL_SEG_W-1:0] b_hi;
      logic [MUL_TAG_W-1:0]            tag;
`ifdef MUL_CPA_STICKY_EN
      logic                            g_hi;   // guard if msb=1
      logic                            g_lo;   // guard if msb=0
      logic                            or_hi;  // sticky if msb=1
      logic                            or_lo;  // sticky if msb=0
`endif
   } mul_s1_t;

endpackage

// File: rtl/mul_final_cpa_pipe_if.sv
// -----------------------------------------------------------------------------
// mul_final_cpa_pipe_if
// Valid/ready input and output channels of mul_final_cpa_pipe. Signal names are
// seen from the adder: i_* are driven by the environment, o_* by the adder.
//   slave  : adder side (inputs i_valid/i_prod_a/i_prod_b/i_tag/i_ready)
//   master : environment side (drives the i_* signals, observes the o_*)
// Optional feature macro: MUL_CPA_STICKY_EN adds o_guard and o_sticky.
// -----------------------------------------------------------------------------
interface mul_final_cpa_pipe_if
   import fpu_mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_PROD_W,
   parameter int unsigned TAG_W = MUL_TAG_W
);

   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_prod_a;
   logic [WIDTH-1:0] i_prod_b;
   logic [TAG_W-1:0] i_tag;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_product;
   logic             o_msb;
   logic             o_carry_out;
   logic [TAG_W-1:0] o_tag;
`ifdef MUL_CPA_STICKY_EN
   logic             o_guard;
   logic             o_sticky;
`endif

   modport master (
      output i_valid, i_prod_a, i_prod_b, i_tag, i_ready,
      input  o_ready, o_valid, o_product, o_msb, o_carry_out, o_tag
`ifdef MUL_CPA_STICKY_EN
      , input o_guard, o_sticky
`endif
   );

   modport slave (
      input  i_valid, i_prod_a, i_prod_b, i_tag, i_ready,
      output o_ready, o_valid, o_product, o_msb, o_carry_out, o_tag
`ifdef MUL_CPA_STICKY_EN
      , output o_guard, o_sticky
`endif
   );

endinterface

// File: rtl/mul_final_cpa_pipe_cpa_segment_add.sv
// -----------------------------------------------------------------------------
// cpa_segment_add
// Plain N-bit binary adder with carry-in and carry-out.
//   a_i, b_i : N-bit operands
//   c_i      : carry in
//   sum_o    : N-bit sum
//   c_o      : carry out of bit N-1
// -----------------------------------------------------------------------------
module cpa_segment_add #(
   parameter int unsigned N = 24
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] sum_o,
   output logic         c_o
);

   assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_i};

endmodule

// File: rtl/mul_final_cpa_pipe.sv
// -----------------------------------------------------------------------------
// mul_final_cpa_pipe
// Two-stage carry-propagate adder resolving the Wallace tree's sum/carry pair.
// Stage 1 adds the low SEG bits; stage 2 adds the high bits plus the segment
// carry. One product per cycle; o_ready depends only on pipeline state and
// i_ready.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : i_valid/o_ready/i_prod_a/i_prod_b/i_tag input channel,
//                    o_valid/i_ready/o_product/o_msb/o_carry_out/o_tag output
// Optional feature macro: MUL_CPA_STICKY_EN adds registered o_guard/o_sticky
// selected by the normalisation MSB.
// -----------------------------------------------------------------------------
module mul_final_cpa_pipe
   import fpu_mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_PROD_W,
   parameter int unsigned SEG   = MUL_SEG_W,
   parameter int unsigned TAG_W = MUL_TAG_W
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   mul_final_cpa_pipe_if.slave bus
);

   localparam int unsigned HI_W = WIDTH - SEG;

   if (SEG == 0 || SEG >= WIDTH) begin : g_bad_seg
      $error("mul_final_cpa_pipe: SEG must satisfy 0 < SEG < WIDTH");
   end
`ifdef MUL_CPA_STICKY_EN
   if (SEG < 3) begin : g_bad_seg_sticky
      $error("mul_final_cpa_pipe: guard/sticky needs SEG >= 3");
   end
   if (WIDTH == MUL_PROD_W && SEG != MUL_SEG_W) begin : g_bad_split
      $error("mul_final_cpa_pipe: SEG must be the mantissa split point");
   end
`endif

   // Same layout as fpu_mul_pkg::mul_s1_t, sized by this instance's parameters.
   typedef struct packed {
      logic [SEG-1:0]   lo;
      logic             c_seg;
      logic [HI_W-1:0]  a_hi;
      logic [HI_W-1:0]  b_hi;
      logic [TAG_W-1:0] tag;
`ifdef MUL_CPA_STICKY_EN
      logic             g_hi;
      logic             g_lo;
      logic             or_hi;
      logic             or_lo;
`endif
   } s1_t;

   logic adv1, adv2, accept;

   s1_t  s1_d, s1_q;
   logic s1_valid_d, s1_valid_q;

   logic             s2_valid_d, s2_valid_q;
   logic [WIDTH-1:0] product_d, product_q;
   logic             carry_d, carry_q;
   logic [TAG_W-1:0] tag_d, tag_q;
`ifdef MUL_CPA_STICKY_EN
   logic             guard_d, guard_q;
   logic             sticky_d, sticky_q;
`endif

   logic [SEG-1:0]  lo_sum;
   logic            lo_carry;
   logic [HI_W-1:0] hi_sum;
   logic            hi_carry;

   // An empty stage always advances, so a stalled output never blocks a
   // bubble in stage 1 from being filled.
   assign adv2        = !s2_valid_q || bus.i_ready;
   assign adv1        = !s1_valid_q || adv2;
   assign accept      = bus.i_valid && adv1;
   assign bus.o_ready = adv1;

   cpa_segment_add #(
      .N (SEG)
   ) u_add_lo (
      .a_i   (bus.i_prod_a[SEG-1:0]),
      .b_i   (bus.i_prod_b[SEG-1:0]),
      .c_i   (1'b0),
      .sum_o (lo_sum),
      .c_o   (lo_carry)
   );

   cpa_segment_add #(
      .N (HI_W)
   ) u_add_hi (
      .a_i   (s1_q.a_hi),
      .b_i   (s1_q.b_hi),
      .c_i   (s1_q.c_seg),
      .sum_o (hi_sum),
      .c_o   (hi_carry)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (adv1) begin
         s1_valid_d = accept;
      end
      if (accept) begin
         s1_d.lo    = lo_sum;
         s1_d.c_seg = lo_carry;
         s1_d.a_hi  = bus.i_prod_a[WIDTH-1:SEG];
         s1_d.b_hi  = bus.i_prod_b[WIDTH-1:SEG];
         s1_d.tag   = bus.i_tag;
`ifdef MUL_CPA_STICKY_EN
         // Guard/sticky candidates for both possible normalisations.
         s1_d.g_hi  = lo_sum[SEG-1];
         s1_d.g_lo  = lo_sum[SEG-2];
         s1_d.or_hi = |lo_sum[SEG-2:0];
         s1_d.or_lo = |lo_sum[SEG-3:0];
`endif
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      product_d  = product_q;
      carry_d    = carry_q;
      tag_d      = tag_q;
`ifdef MUL_CPA_STICKY_EN
      guard_d    = guard_q;
      sticky_d   = sticky_q;
`endif
      if (adv2) begin
         s2_valid_d = s1_valid_q;
      end
      if (adv2 && s1_valid_q) begin
         product_d = {hi_sum, s1_q.lo};
         carry_d   = hi_carry;
         tag_d     = s1_q.tag;
`ifdef MUL_CPA_STICKY_EN
         guard_d   = hi_sum[HI_W-1] ? s1_q.g_hi  : s1_q.g_lo;
         sticky_d  = hi_sum[HI_W-1] ? s1_q.or_hi : s1_q.or_lo;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         product_q  <= '0;
         carry_q    <= 1'b0;
         tag_q      <= '0;
`ifdef MUL_CPA_STICKY_EN
         guard_q    <= 1'b0;
         sticky_q   <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         product_q  <= product_d;
         carry_q    <= carry_d;
         tag_q      <= tag_d;
`ifdef MUL_CPA_STICKY_EN
         guard_q    <= guard_d;
         sticky_q   <= sticky_d;
`endif
      end
   end

   assign bus.o_valid     = s2_valid_q;
   assign bus.o_product   = product_q;
   assign bus.o_msb       = product_q[WIDTH-1];
   assign bus.o_carry_out = carry_q;
   assign bus.o_tag       = tag_q;
`ifdef MUL_CPA_STICKY_EN
   assign bus.o_guard     = guard_q;
   assign bus.o_sticky    = sticky_q;
`endif

endmodule

// File: doc/mul_final_cpa_pipe.md
Name: mul_final_cpa_pipe

Overview:
- Two-stage pipelined carry-propagate adder for the FPU mantissa multiplier.
- Sits directly downstream of the Wallace tree's final 3:2 merge and consumes its sum vector A and left-shifted carry vector B.
- Produces the resolved binary product, its normalisation MSB, a carry-out, and optional guard/sticky bits for the rounder.
- Valid/ready handshake on both sides; full throughput of one product per cycle.

Parameters:
- WIDTH, 48, product width; equals the width of the A and B vectors.
- SEG, 24, low-segment width added in stage 1; the constraint 0 < SEG < WIDTH is checked at elaboration.
- TAG_W, 4, sideband tag width; the tag is carried unchanged alongside the data.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input vectors are valid.
- o_ready  out  1  block can accept an input this cycle.
- i_prod_a  in  WIDTH  sum vector from the merge stage.
- i_prod_b  in  WIDTH  carry vector from the merge stage, already shifted.
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  output product is valid.
- i_ready  in  1  downstream accepts the output.
- o_product  out  WIDTH  A+B modulo 2^WIDTH.
- o_msb  out  1  o_product[WIDTH-1], the normalisation select.
- o_carry_out  out  1  carry out of bit WIDTH-1; always 0 for legal mantissa products.
- o_tag  out  TAG_W  tag delivered with the product.
- o_guard  out  1  guard bit; present only with the optional feature.
- o_sticky  out  1  sticky bit; present only with the optional feature.

Behaviour:
- Reset: s1_valid, s2_valid, o_valid, o_product, o_msb, o_carry_out, o_tag, o_guard and o_sticky are all 0. o_ready is 1 after reset.
- Stage 1:
  - Computes {c_seg, lo} = A[SEG-1:0] + B[SEG-1:0].
  - Registers lo, c_seg, A[WIDTH-1:SEG], B[WIDTH-1:SEG] and the tag, then sets s1_valid.
- Stage 2:
  - Computes {carry_out, hi} = A_hi + B_hi + c_seg.
  - Registers the output as product = {hi, lo} together with msb, carry_out and tag, then sets s2_valid (this is o_valid).
- Latency: 2 cycles from input handshake to o_valid with no stall.
- Advance rules:
  - adv2 = !s2_valid | i_ready.
  - adv1 = !s1_valid | adv2.
  - o_ready = adv1.
  - Input accepted when i_valid & o_ready.
- Bubble collapse: an empty stage always loads, so a stall at the output does not block an empty stage 1.
- Output stability: while o_valid=1 and i_ready=0, every output holds stable.
- Valid transitions:
  - s1_valid <= (i_valid & o_ready) when adv1; otherwise held.
  - s2_valid <= s1_valid when adv2; otherwise held.
- Simultaneous events: output drain and new input in the same cycle is full throughput, with no bubble.
- Wrap-around: A+B ≥ 2^WIDTH truncates o_product and sets o_carry_out=1.
- Data registers load only on advance; no combinational path from i_prod_a/i_prod_b to any output.
- Reset mid-operation: all in-flight items are dropped and valids cleared immediately (asynchronous). No output is produced for items lost this way.
- Combinational paths: o_ready depends combinationally on i_ready. No path exists from i_valid to o_ready.

Optional Feature:
- Macro: MUL_CPA_STICKY_EN.
- Defined, stage 1:
  - Additionally registers or_hi = |lo[SEG-2:0] and or_lo = |lo[SEG-3:0], the sticky candidates for both normalisations.
  - Registers g_hi = lo[SEG-1] and g_lo = lo[SEG-2], the guard candidates.
- Defined, stage 2 selects on msb:
  - msb=1: o_guard = g_hi, o_sticky = or_hi.
  - msb=0: o_guard = g_lo, o_sticky = or_lo.
  - The guard/sticky bits follow the same valid/stall rules as the product.
- Defined, constraint: SEG must equal the mantissa split point, which is 24 for WIDTH=48.
- Undefined: the o_guard and o_sticky ports and their registers are absent.

Decomposition:
- Shared package fpu_mul_pkg holds:
  - MUL_PROD_W = 48 and MUL_SEG_W = 24.
  - Typedef mul_prod_t (logic [MUL_PROD_W-1:0]).
  - Typedef mul_s1_t, a packed struct of lo, c_seg, a_hi, b_hi, tag and the optional guard/sticky fields.
- One sub-module, cpa_segment_add: a parameterised width-N adder with carry-in and carry-out, instantiated once per stage.

Test Plan:
- Segment-boundary carry: A=0x0000_00FF_FFFF, B=0x0000_0000_0001, i_ready=1 -> after 2 cycles o_product=0x0000_0100_0000, o_msb=0, o_carry_out=0.
- Overflow: A=B=0x8000_0000_0000 -> o_product=0, o_carry_out=1, o_msb=0.
- Streaming with stall:
  - Stimulus: 4 back-to-back inputs with tags 1..4; i_ready held 0 for cycles 3..5.
  - Required: o_ready drops only once both stages are full; outputs hold stable during the stall.
  - Required: after release, products emerge in tag order 1..4 with none lost or duplicated.
- Reset mid-operation: 2 items in flight, assert i_rst_n=0 asynchronously -> o_valid=0 immediately, o_product=0, o_ready=1 after release, no stale output afterwards.
- Sticky, msb=1 (feature defined): A=0x8000_0000_0000, B=0x0000_0000_0001 -> o_product=0x8000_0000_0001, o_msb=1, o_guard=0, o_sticky=1.
- Guard, msb=0 (feature defined): A=0x4000_0000_0000, B=0x0000_0040_0000 -> o_msb=0, o_guard=1, o_sticky=0.
